// File: rtl/arb2_mux_ctrl.sv
// Two-requester round-robin packet arbiter driving a shared valid/ready channel.
// Grants are held until the granted packet ends or MAX_BURST beats have transferred.
module arb2_mux_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic             a_last,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic             b_last,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;   // 1 = B was served most recently
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;

    logic             grant_last;
    logic             hs;
    logic             release_now;
    logic [CNT_W-1:0] cnt_inc;

    // Datapath mux and readies follow the registered grant
    always_comb begin
        out_valid  = 1'b0;
        out_data   = '0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        grant_last = 1'b0;
        case (state_q)
            GNT_A: begin
                out_valid  = a_valid;
                out_data   = a_data;
                a_ready    = out_ready;
                grant_last = a_last;
            end
            GNT_B: begin
                out_valid  = b_valid;
                out_data   = b_data;
                b_ready    = out_ready;
                grant_last = b_last;
            end
            default: begin
                out_valid  = 1'b0;
            end
        endcase
    end

    assign hs          = out_valid & out_ready;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign release_now = hs & (grant_last | (cnt_inc == MAX_CNT));

    // Next-state: arbitration in IDLE, release/hand-over while granted
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (a_valid && (!b_valid || last_b_q)) begin
                    state_d = GNT_A;
                    cnt_d   = '0;
                    sel_d   = 1'b0;
                    busy_d  = 1'b1;
                end else if (b_valid) begin
                    state_d = GNT_B;
                    cnt_d   = '0;
                    sel_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            GNT_A: begin
                if (release_now) begin
                    last_b_d = 1'b0;
                    cnt_d    = '0;
                    if (b_valid) begin
                        state_d = GNT_B;
                        sel_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (hs) begin
                    cnt_d = cnt_inc;
                end
            end
            GNT_B: begin
                if (release_now) begin
                    last_b_d = 1'b1;
                    cnt_d    = '0;
                    if (a_valid) begin
                        state_d = GNT_A;
                        sel_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (hs) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// Scenario bench for arb2_mux_ctrl: MAX_BURST=4 and MAX_BURST=1 instances share stimulus.
module tb_arb2_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_last, b_valid, b_last, out_ready;
    logic [7:0] a_data, b_data;

    logic       a_ready4, b_ready4, out_valid4, sel4, busy4;
    logic [7:0] out_data4;
    logic       a_ready1, b_ready1, out_valid1, sel1, busy1;
    logic [7:0] out_data1;

    int         checks = 0;
    int         passed = 0;
    logic [8:0] sbq[$];
    int         a_idx, b_idx, a_lb, b_lb;
    bit         use_d1 = 1'b0;
    logic [9:0] ob;
    logic [8:0] ex;

    always #5 clk = ~clk;

    arb2_mux_ctrl #(.WIDTH(8), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_last(a_last), .a_data(a_data), .a_ready(a_ready4),
        .b_valid(b_valid), .b_last(b_last), .b_data(b_data), .b_ready(b_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
        .sel(sel4), .busy(busy4)
    );

    arb2_mux_ctrl #(.WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_last(a_last), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_last(b_last), .b_data(b_data), .b_ready(b_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
        .sel(sel1), .busy(busy1)
    );

    // Source beats: A sends A0,A1,..., B sends B0,B1,...; index restarts after a last beat
    task automatic set_src();
        a_data = 8'(160 + a_idx);
        b_data = 8'(176 + b_idx);
        a_last = (a_lb != 0) && (a_idx + 1 == a_lb);
        b_last = (b_lb != 0) && (b_idx + 1 == b_lb);
    endtask

    function automatic logic [9:0] obs_beat();
        if (use_d1) return {out_valid1 & out_ready, sel1, out_data1};
        return {out_valid4 & out_ready, sel4, out_data4};
    endfunction

    task automatic advance();
        logic ha, hb;
        ha = a_valid & (use_d1 ? a_ready1 : a_ready4);
        hb = b_valid & (use_d1 ? b_ready1 : b_ready4);
        @(posedge clk); #1;
        if (ha) a_idx = a_last ? 0 : a_idx + 1;
        if (hb) b_idx = b_last ? 0 : b_idx + 1;
        set_src();
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        a_idx = 0; b_idx = 0; a_lb = 0; b_lb = 0;
        set_src();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        sbq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        a_idx = 0; b_idx = 0; a_lb = 0; b_lb = 0; set_src();
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({out_valid4, a_ready4, b_ready4, sel4, busy4} !== 5'b0) $display("FAIL reset_outputs4: got %b expected %b", {out_valid4, a_ready4, b_ready4, sel4, busy4}, 5'b0); else passed++;
        checks++; if ({out_valid1, a_ready1, b_ready1, sel1, busy1} !== 5'b0) $display("FAIL reset_outputs1: got %b expected %b", {out_valid1, a_ready1, b_ready1, sel1, busy1}, 5'b0); else passed++;
        @(posedge clk); #1;
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_rr_switch();
        do_reset();
        a_lb = 2; set_src();
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        sbq.push_back({1'b0, 8'hA0}); sbq.push_back({1'b0, 8'hA1});
        sbq.push_back({1'b1, 8'hB0}); sbq.push_back({1'b1, 8'hB1});
        sbq.push_back({1'b1, 8'hB2}); sbq.push_back({1'b1, 8'hB3});
        sbq.push_back({1'b0, 8'hA0});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if ({out_valid4, busy4} !== 2'b00) $display("FAIL rr_idle: got %b expected %b", {out_valid4, busy4}, 2'b00); else passed++;
            end
            if (c == 3) begin
                checks++; if ({out_valid4, sel4, busy4} !== 3'b111) $display("FAIL rr_no_bubble: got %b expected %b", {out_valid4, sel4, busy4}, 3'b111); else passed++;
            end
            ob = obs_beat();
            if (ob[9]) begin
                ex = (sbq.size() != 0) ? sbq.pop_front() : 9'h1FF;
                checks++; if (ob[8:0] !== ex) $display("FAIL rr_beat c%0d: got %h expected %h", c, ob[8:0], ex); else passed++;
            end
            advance();
        end
        checks++; if (sbq.size() != 0) $display("FAIL rr_leftover: got %0d expected 0", sbq.size()); else passed++;
    endtask

    task automatic test_max_burst();
        do_reset();
        a_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) sbq.push_back({1'b0, 8'(160 + i)});
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 5 || c == 10) begin
                checks++; if ({out_valid4, busy4} !== 2'b00) $display("FAIL burst_gap c%0d: got %b expected %b", c, {out_valid4, busy4}, 2'b00); else passed++;
            end
            ob = obs_beat();
            if (ob[9]) begin
                ex = (sbq.size() != 0) ? sbq.pop_front() : 9'h1FF;
                checks++; if (ob[8:0] !== ex) $display("FAIL burst_beat c%0d: got %h expected %h", c, ob[8:0], ex); else passed++;
            end
            advance();
        end
        checks++; if (sbq.size() != 0) $display("FAIL burst_leftover: got %0d expected 0", sbq.size()); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        b_lb = 4; set_src();
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) sbq.push_back({1'b1, 8'(176 + i)});
        for (int c = 0; c < 9; c++) begin
            out_ready = (c == 0) ? 1'b1 : ((c % 2) == 1);
            @(negedge clk);
            if (c == 2 || c == 4 || c == 6) begin
                checks++; if ({b_ready4, busy4, sel4} !== 3'b011) $display("FAIL stall_hold c%0d: got %b expected %b", c, {b_ready4, busy4, sel4}, 3'b011); else passed++;
            end
            if (c == 8) begin
                checks++; if (busy4 !== 1'b0) $display("FAIL stall_release: got %b expected %b", busy4, 1'b0); else passed++;
            end
            ob = obs_beat();
            if (ob[9]) begin
                ex = (sbq.size() != 0) ? sbq.pop_front() : 9'h1FF;
                checks++; if (ob[8:0] !== ex) $display("FAIL stall_beat c%0d: got %h expected %h", c, ob[8:0], ex); else passed++;
            end
            advance();
        end
        checks++; if (sbq.size() != 0) $display("FAIL stall_leftover: got %0d expected 0", sbq.size()); else passed++;
    endtask

    task automatic test_valid_drop();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) sbq.push_back({1'b0, 8'(160 + i)});
        sbq.push_back({1'b1, 8'hB0});
        for (int c = 0; c < 9; c++) begin
            a_valid = !(c >= 2 && c <= 4);
            b_valid = (c >= 2);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++; if ({out_valid4, sel4, busy4, b_ready4} !== 4'b0010) $display("FAIL drop_hold c%0d: got %b expected %b", c, {out_valid4, sel4, busy4, b_ready4}, 4'b0010); else passed++;
            end
            ob = obs_beat();
            if (ob[9]) begin
                ex = (sbq.size() != 0) ? sbq.pop_front() : 9'h1FF;
                checks++; if (ob[8:0] !== ex) $display("FAIL drop_beat c%0d: got %h expected %h", c, ob[8:0], ex); else passed++;
            end
            advance();
        end
        checks++; if (sbq.size() != 0) $display("FAIL drop_leftover: got %0d expected 0", sbq.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        b_valid = 1'b1; out_ready = 1'b1;
        sbq.push_back({1'b1, 8'hB0}); sbq.push_back({1'b1, 8'hB1});
        sbq.push_back({1'b0, 8'hA0});
        for (int c = 0; c < 5; c++) begin
            rst = (c == 2);
            if (c == 3) a_valid = 1'b1;
            @(negedge clk);
            if (c == 3) begin
                checks++; if ({out_valid4, a_ready4, b_ready4, sel4, busy4} !== 5'b0) $display("FAIL midrst_idle: got %b expected %b", {out_valid4, a_ready4, b_ready4, sel4, busy4}, 5'b0); else passed++;
            end
            ob = obs_beat();
            if (ob[9]) begin
                ex = (sbq.size() != 0) ? sbq.pop_front() : 9'h1FF;
                checks++; if (ob[8:0] !== ex) $display("FAIL midrst_beat c%0d: got %h expected %h", c, ob[8:0], ex); else passed++;
            end
            advance();
        end
        checks++; if (sbq.size() != 0) $display("FAIL midrst_leftover: got %0d expected 0", sbq.size()); else passed++;
    endtask

    task automatic test_rr_idle();
        do_reset();
        a_lb = 1; set_src();
        a_valid = 1'b1; out_ready = 1'b1;
        sbq.push_back({1'b0, 8'hA0}); sbq.push_back({1'b1, 8'hB0});
        for (int c = 0; c < 4; c++) begin
            b_valid = (c >= 2);
            @(negedge clk);
            if (c == 2) begin
                checks++; if ({out_valid4, busy4} !== 2'b00) $display("FAIL rridle_gap: got %b expected %b", {out_valid4, busy4}, 2'b00); else passed++;
            end
            ob = obs_beat();
            if (ob[9]) begin
                ex = (sbq.size() != 0) ? sbq.pop_front() : 9'h1FF;
                checks++; if (ob[8:0] !== ex) $display("FAIL rridle_beat c%0d: got %h expected %h", c, ob[8:0], ex); else passed++;
            end
            advance();
        end
        checks++; if (sbq.size() != 0) $display("FAIL rridle_leftover: got %0d expected 0", sbq.size()); else passed++;
    endtask

    task automatic test_burst1();
        use_d1 = 1'b1;
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back({1'b0, 8'(160 + i)});
            sbq.push_back({1'b1, 8'(176 + i)});
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++; if (busy1 !== (c != 0)) $display("FAIL b1_busy c%0d: got %b expected %b", c, busy1, (c != 0)); else passed++;
            ob = obs_beat();
            if (ob[9]) begin
                ex = (sbq.size() != 0) ? sbq.pop_front() : 9'h1FF;
                checks++; if (ob[8:0] !== ex) $display("FAIL b1_beat c%0d: got %h expected %h", c, ob[8:0], ex); else passed++;
            end
            advance();
        end
        checks++; if (sbq.size() != 0) $display("FAIL b1_leftover: got %0d expected 0", sbq.size()); else passed++;
        use_d1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_switch();
        test_max_burst();
        test_stall();
        test_valid_drop();
        test_reset_mid();
        test_rr_idle();
        test_burst1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/arb2_mux_ctrl.md
ARB2_MUX_CTRL -- requirements
Module: arb2_mux_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of each channel.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, maximum beats per grant, legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports a_valid, a_last  input  1 each  requester A beat valid / final beat of A's packet.
REQ-006 The block SHALL have port a_data  input  WIDTH  requester A data.
REQ-007 The block SHALL have port a_ready  output  1  A beat accepted when a_valid and a_ready are both 1.
REQ-008 The block SHALL have ports b_valid, b_last, b_data, b_ready with the same widths and meaning for requester B.
REQ-009 The block SHALL have ports out_valid (output, 1), out_data (output, WIDTH), out_ready (input, 1)  shared downstream channel.
REQ-010 The block SHALL have port sel  output  1  mux select: 0 = A, 1 = B.
REQ-011 The block SHALL have port busy  output  1  high while a grant is held.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GNT_A, GNT_B.
REQ-013 In IDLE: out_valid=0, a_ready=0, b_ready=0, busy=0, sel holds its last value.
REQ-014 In IDLE, only a_valid=1 -> GNT_A next cycle; only b_valid=1 -> GNT_B next cycle; neither -> stay IDLE.
REQ-015 In IDLE with both valid, the requester not recorded in last_served SHALL win (round-robin).
REQ-016 Arbitration latency SHALL be one cycle: request seen in IDLE at edge N, first beat can transfer in cycle N+1.
REQ-017 In GNT_A: sel=0, busy=1, out_valid=a_valid, out_data=a_data, a_ready=out_ready, b_ready=0; GNT_B symmetric with sel=1.
REQ-018 out_data, out_valid, a_ready and b_ready SHALL be combinational from the registered state and inputs; sel and busy SHALL be registered.
REQ-019 A beat counter (4 bits) SHALL clear on entry to GNT_A/GNT_B and increment on every handshake (out_valid & out_ready).
REQ-020 Release SHALL occur on the handshake of a beat with the granted last=1, or on the handshake that makes the count equal MAX_BURST, whichever comes first.
REQ-021 On release, last_served SHALL be set to the releasing requester.
REQ-022 On release, if the other requester's valid is 1 in that cycle the FSM SHALL go directly to its grant state (no idle bubble); otherwise to IDLE.
REQ-023 A granted requester dropping valid mid-packet SHALL NOT release the grant; the grant holds indefinitely until REQ-020.
REQ-024 out_ready=0 SHALL stall: counter, state and last_served unchanged.
REQ-025 The non-granted requester's valid, last and data SHALL have no effect on any output except through REQ-022.
REQ-026 MAX_BURST=1 SHALL release after every beat, alternating A/B when both stay valid.

Reset
REQ-027 While rst=1 at a rising clk edge: state=IDLE, counter=0, last_served=B, sel=0, busy=0; hence out_valid=0, a_ready=0, b_ready=0 the following cycle.
REQ-028 Reset asserted mid-grant SHALL abandon the packet without completing it; after rst falls, A SHALL win the first simultaneous request.

Verification
REQ-029 Reset, then a_valid=b_valid=1 continuously, a_last on beat 2, out_ready=1 -> GNT_A beats 1-2 (sel=0), then GNT_B directly next cycle (sel=1).
REQ-030 MAX_BURST=4, only A valid, a_last never 1 -> exactly 4 handshakes, then IDLE one cycle, then GNT_A again, counter restarted at 0.
REQ-031 GNT_B, out_ready toggles 1,0,1,0 for 8 cycles with b_last on beat 4 -> 4 handshakes only on out_ready=1 cycles, release on 4th, b_ready=0 while out_ready=0.
REQ-032 GNT_A, a_valid drops to 0 for 3 cycles mid-packet while b_valid=1 -> out_valid=0, sel=0, busy=1, no switch to B.
REQ-033 rst=1 asserted on beat 2 of a GNT_B packet -> next cycle IDLE, all readies 0, sel=0; on release with both valid, A granted first.
REQ-034 MAX_BURST=1, both valid, out_ready=1 for 6 cycles -> out_data sequence A,B,A,B,A,B after first grant, busy stays 1.
